pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register, the successor to our fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload plus a halt flag between two stages with a valid/ready handshake, optional one-entry skid buffer, synchronous flush, and a sticky halt latch. It replaces hand-written per-stage registers so every stage boundary gains stall and flush support uniformly.

## Interface
- PAYLOAD_W, 40, payload width in bits; the caller packs ctrl bits, rd, ALU result and store data.
- SKID, 1, 1 = two-entry (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.
- clk  input  1  stage clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous kill of all held beats.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- in_data  input  PAYLOAD_W  upstream payload.
- in_halt  input  1  beat is a HLT instruction.
- out_valid  output  1  main entry holds a beat.
- out_ready  input  1  downstream accepts.
- out_data  output  PAYLOAD_W  main entry payload.
- out_halt  output  1  halt flag of the main entry.
- halted  output  1  sticky: a halt beat has left the stage.
- occupancy  output  2  beats held (0..2; max 1 when SKID=0).

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State (pipe_state_t): P_EMPTY, P_MAIN, P_BOTH (P_BOTH unreachable when SKID=0).
- P_EMPTY: in_fire -> load main, go P_MAIN.
- P_MAIN: in_fire & out_fire -> main <= in, stay; in_fire & !out_fire -> skid <= in, go P_BOTH; !in_fire & out_fire -> P_EMPTY; neither -> hold.
- P_BOTH: no in_fire possible; out_fire -> main <= skid, go P_MAIN; else hold.
- in_ready, SKID=1: registered, equals !(next state == P_BOTH) & !halted_next.
- in_ready, SKID=0: (!out_valid | out_ready) & !halted.
- Payload and halt flag are loaded only on a load event; otherwise held unchanged (no X or garbage propagation when input is idle).
- flush: highest priority; next state P_EMPTY, out_valid/occupancy 0 next cycle. A beat accepted by in_fire in the flush cycle is discarded. A beat delivered by out_fire in the flush cycle counts as delivered. Payload registers keep their old contents.
- halted: set on the cycle after out_fire with out_halt=1; cleared only by rst_n; flush does not clear it. While halted, in_ready=0; beats already held still drain.
- occupancy = number of entries valid (P_EMPTY 0, P_MAIN 1, P_BOTH 2).

## Timing
- Reset values: out_valid 0, out_data 0, out_halt 0, halted 0, occupancy 0, in_ready 1 (both SKID settings), state P_EMPTY, skid cleared.
- Latency: in_fire in cycle N -> out_valid with that payload in N+1 (P_EMPTY or P_MAIN with out_fire).
- Throughput: 1 beat/cycle sustained with out_ready=1.
- SKID=1: out_ready deassertion affects in_ready one cycle later; skid absorbs the in-flight beat, no loss.
- Simultaneous flush + in_fire + out_fire: out beat delivered, in beat dropped, state P_EMPTY.
- Reset mid-operation: all held beats lost immediately (async), outputs at reset values before next edge.
- Order preserved: beats leave in acceptance order; skid beat never overtakes main.

## Structure
- Shared package pipe_pkg: typedef enum logic [1:0] pipe_state_t {P_EMPTY, P_MAIN, P_BOTH}; localparam OCC_W = 2.
- Sub-module pipe_slot: PAYLOAD_W+1-bit load-enabled register with valid bit, async active-low reset; instantiated as main and skid (skid generated only when SKID=1).

## Test plan
- Reset then in_valid=1, in_data=0x00000000A5, out_ready=1 -> out_valid=1, out_data=0xA5 next cycle, occupancy=1.
- SKID=1, stream 0x1,0x2,0x3 with out_ready dropped in cycle 2 -> occupancy reaches 2, in_ready=0 next cycle; on out_ready=1 outputs 0x1,0x2,0x3 in order, none lost or duplicated.
- SKID=0, out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.
- P_BOTH, flush=1 with out_ready=1 -> main beat delivered that cycle, next cycle out_valid=0, occupancy=0, skid beat never appears.
- Beat with in_halt=1 delivered -> halted=1 next cycle, in_ready=0 thereafter; flush leaves halted=1; rst_n low clears it.
- rst_n asserted low while occupancy=2 -> out_valid=0, occupancy=0, in_ready=1 without a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    P_EMPTY = 2'd0,
    P_MAIN  = 2'd1,
    P_BOTH  = 2'd2
  } pipe_state_t;

  localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the stage: load-enabled payload register plus valid bit.
module pipe_slot #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         valid_d,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // Valid follows the stage state every cycle; payload changes only on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= valid_d;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with optional skid entry, flush and sticky halt.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 40,
  parameter int SKID      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic                 in_halt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic                 out_halt,
  output logic                 halted,
  output logic [OCC_W-1:0]     occupancy
);

  localparam int SW = PAYLOAD_W + 1;

  pipe_state_t   state, next_state;
  logic          in_fire, out_fire;
  logic          main_load, skid_load, main_from_skid;
  logic          main_vld, skid_vld;
  logic [SW-1:0] main_d, main_q, skid_q;
  logic          halted_next;

  assign out_valid = main_vld;
  assign out_data  = main_q[PAYLOAD_W-1:0];
  assign out_halt  = main_q[PAYLOAD_W];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};

  // A halt beat leaving the stage latches halted until reset; flush does not clear it.
  assign halted_next = halted | (out_fire & out_halt);

  // Next-state and load selection; flush overrides everything and discards any load.
  always_comb begin
    next_state     = state;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      P_EMPTY: begin
        if (in_fire) begin
          main_load  = 1'b1;
          next_state = P_MAIN;
        end
      end
      P_MAIN: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire && (SKID != 0)) begin
          skid_load  = 1'b1;
          next_state = P_BOTH;
        end else if (out_fire) begin
          next_state = P_EMPTY;
        end
      end
      P_BOTH: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          next_state     = P_MAIN;
        end
      end
      default: next_state = P_EMPTY;
    endcase
    if (flush) begin
      next_state = P_EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= P_EMPTY;
    else        state <= next_state;
  end

  // Sticky halt latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted <= 1'b0;
    else        halted <= halted_next;
  end

  assign main_d = main_from_skid ? skid_q : {in_halt, in_data};

  pipe_slot #(.W(SW)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_load),
    .valid_d (next_state != P_EMPTY),
    .d       (main_d),
    .q       (main_q),
    .valid   (main_vld)
  );

  if (SKID != 0) begin : g_skid
    logic in_ready_q;

    pipe_slot #(.W(SW)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (skid_load),
      .valid_d (next_state == P_BOTH),
      .d       ({in_halt, in_data}),
      .q       (skid_q),
      .valid   (skid_vld)
    );

    // Registered ready: drops the cycle after the skid entry fills or halt latches.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) in_ready_q <= 1'b1;
      else        in_ready_q <= (next_state != P_BOTH) & ~halted_next;
    end

    assign in_ready = in_ready_q;
  end else begin : g_noskid
    assign skid_q   = '0;
    assign skid_vld = 1'b0;
    assign in_ready = (~out_valid | out_ready) & ~halted;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int PW = 40;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_halt, out_ready;
  logic [PW-1:0] in_data;
  logic          ir1, ov1, oh1, hd1;
  logic [PW-1:0] od1;
  logic [1:0]    occ1;
  logic          ir0, ov0, oh0, hd0;
  logic [PW-1:0] od0;
  logic [1:0]    occ0;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(.PAYLOAD_W(PW), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .in_halt(in_halt), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_halt(oh1), .halted(hd1), .occupancy(occ1)
  );

  pipe_stage_skid #(.PAYLOAD_W(PW), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .in_halt(in_halt), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_halt(oh0), .halted(hd0), .occupancy(occ0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          iv;
    logic [PW-1:0] d;
    logic          hlt;
    logic          ordy;
    logic          fl;
    logic          e_ov;
    logic [PW-1:0] e_od;
    logic          e_oh;
    logic [1:0]    e_occ;
    logic          e_ir;
    logic          e_hd;
  } vec_t;

  vec_t v [17];

  // Scoreboard of beats delivered by the SKID=1 instance, sampled mid-cycle.
  logic [PW-1:0] delivered [$];
  logic          mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && ov1 && out_ready) delivered.push_back(od1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_data = '0; in_halt = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  logic [PW-1:0] exp_q [$];

  initial begin
    //          iv d        h  or fl   ov od       oh occ ir hd
    v[0]  = '{1'b1, 40'h00000000A5, 1'b0, 1'b1, 1'b0, 1'b1, 40'hA5, 1'b0, 2'd1, 1'b1, 1'b0};
    v[1]  = '{1'b1, 40'h1,  1'b0, 1'b1, 1'b0, 1'b1, 40'h1,  1'b0, 2'd1, 1'b1, 1'b0};
    v[2]  = '{1'b1, 40'h2,  1'b0, 1'b0, 1'b0, 1'b1, 40'h1,  1'b0, 2'd2, 1'b0, 1'b0};
    v[3]  = '{1'b1, 40'h3,  1'b0, 1'b0, 1'b0, 1'b1, 40'h1,  1'b0, 2'd2, 1'b0, 1'b0};
    v[4]  = '{1'b1, 40'h3,  1'b0, 1'b1, 1'b0, 1'b1, 40'h2,  1'b0, 2'd1, 1'b1, 1'b0};
    v[5]  = '{1'b1, 40'h3,  1'b0, 1'b1, 1'b0, 1'b1, 40'h3,  1'b0, 2'd1, 1'b1, 1'b0};
    v[6]  = '{1'b0, 40'h77, 1'b0, 1'b1, 1'b0, 1'b0, 40'h3,  1'b0, 2'd0, 1'b1, 1'b0};
    v[7]  = '{1'b0, 40'h0,  1'b0, 1'b0, 1'b0, 1'b0, 40'h3,  1'b0, 2'd0, 1'b1, 1'b0};
    v[8]  = '{1'b1, 40'h10, 1'b0, 1'b0, 1'b0, 1'b1, 40'h10, 1'b0, 2'd1, 1'b1, 1'b0};
    v[9]  = '{1'b1, 40'h11, 1'b0, 1'b0, 1'b0, 1'b1, 40'h10, 1'b0, 2'd2, 1'b0, 1'b0};
    v[10] = '{1'b0, 40'h0,  1'b0, 1'b1, 1'b1, 1'b0, 40'h10, 1'b0, 2'd0, 1'b1, 1'b0};
    v[11] = '{1'b0, 40'h0,  1'b0, 1'b1, 1'b0, 1'b0, 40'h10, 1'b0, 2'd0, 1'b1, 1'b0};
    v[12] = '{1'b1, 40'h20, 1'b0, 1'b1, 1'b1, 1'b0, 40'h10, 1'b0, 2'd0, 1'b1, 1'b0};
    v[13] = '{1'b1, 40'h30, 1'b1, 1'b0, 1'b0, 1'b1, 40'h30, 1'b1, 2'd1, 1'b1, 1'b0};
    v[14] = '{1'b0, 40'h0,  1'b0, 1'b1, 1'b0, 1'b0, 40'h30, 1'b1, 2'd0, 1'b0, 1'b1};
    v[15] = '{1'b1, 40'h40, 1'b0, 1'b1, 1'b0, 1'b0, 40'h30, 1'b1, 2'd0, 1'b0, 1'b1};
    v[16] = '{1'b0, 40'h0,  1'b0, 1'b0, 1'b1, 1'b0, 40'h30, 1'b1, 2'd0, 1'b0, 1'b1};
    exp_q = '{40'hA5, 40'h1, 40'h2, 40'h3, 40'h10, 40'h30};

    // Reset values
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_out_valid", 64'(ov1), 64'd0);
    chk("rst_out_data", 64'(od1), 64'd0);
    chk("rst_occupancy", 64'(occ1), 64'd0);
    chk("rst_in_ready", 64'(ir1), 64'd1);
    chk("rst_halted", 64'(hd1), 64'd0);
    chk("rst_in_ready_noskid", 64'(ir0), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Table-driven sequence on the skid instance
    for (int i = 0; i < 17; i++) begin
      in_valid = v[i].iv; in_data = v[i].d; in_halt = v[i].hlt;
      out_ready = v[i].ordy; flush = v[i].fl;
      tick();
      chk($sformatf("v%0d_out_valid", i), 64'(ov1), 64'(v[i].e_ov));
      chk($sformatf("v%0d_out_data", i), 64'(od1), 64'(v[i].e_od));
      chk($sformatf("v%0d_out_halt", i), 64'(oh1), 64'(v[i].e_oh));
      chk($sformatf("v%0d_occupancy", i), 64'(occ1), 64'(v[i].e_occ));
      chk($sformatf("v%0d_in_ready", i), 64'(ir1), 64'(v[i].e_ir));
      chk($sformatf("v%0d_halted", i), 64'(hd1), 64'(v[i].e_hd));
    end
    idle();
    mon_en = 1'b0;

    // Delivered order: no loss, duplication or overtaking; flushed skid beat absent
    chk("delivered_count", 64'(delivered.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < delivered.size(); i++)
      chk($sformatf("delivered_%0d", i), 64'(delivered[i]), 64'(exp_q[i]));

    // Reset clears halted; then async reset while two beats are held
    rst_n = 1'b0;
    #1;
    chk("rst_clears_halted", 64'(hd1), 64'd0);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 40'h55; out_ready = 1'b0;
    tick();
    in_data = 40'h66;
    tick();
    chk("pre_async_occ", 64'(occ1), 64'd2);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(ov1), 64'd0);
    chk("async_occupancy", 64'(occ1), 64'd0);
    chk("async_in_ready", 64'(ir1), 64'd1);
    chk("async_out_data", 64'(od1), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single-entry instance: combinational ready
    in_valid = 1'b1; in_data = 40'h50; out_ready = 1'b0;
    #1;
    chk("ns_ready_empty", 64'(ir0), 64'd1);
    tick();
    chk("ns_out_valid", 64'(ov0), 64'd1);
    chk("ns_out_data", 64'(od0), 64'h50);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("ns_ready_blocked", 64'(ir0), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("ns_ready_same_cycle", 64'(ir0), 64'd1);
    in_valid = 1'b1; in_data = 40'h51;
    tick();
    chk("ns_thru_data", 64'(od0), 64'h51);
    chk("ns_thru_occ", 64'(occ0), 64'd1);
    in_data = 40'h52; out_ready = 1'b0;
    tick();
    chk("ns_hold_data", 64'(od0), 64'h51);
    chk("ns_hold_occ", 64'(occ0), 64'd1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
